// File: rtl/cs_pkg.sv
// ---------------------------------------------------------------------------
// cs_pkg -- shared definitions for the checksum job scheduler.
//
// Holds the default payload/result widths, the default engine timeout, the
// wait-counter width, the scheduler FSM state encoding and the one-hot grant
// codes used between the arbiter and the scheduler.
// ---------------------------------------------------------------------------
package cs_pkg;

  // Default payload: 384-bit field 1 + 128-bit field 2.
  localparam int DEF_WIDTH_DATA   = 512;
  // Default result: 8-bit result 1 + 8-bit result 2.
  localparam int DEF_WIDTH_RESULT = 16;
  // Default number of WAIT cycles before a job is abandoned.
  localparam int DEF_TIMEOUT      = 1023;

  // Wait counter is wide enough for the largest legal TIMEOUT (65535).
  localparam int CNT_W = 16;

  // Scheduler states; encodings kept fixed for compatibility with older
  // register maps that expose the state for debug.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // One-hot grant encoding: bit 0 = requester A, bit 1 = requester B.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A    = 2'b01;
  localparam logic [1:0] GNT_B    = 2'b10;

endpackage : cs_pkg

// File: rtl/cs_rr_arb2.sv
// ---------------------------------------------------------------------------
// cs_rr_arb2 -- two-way round-robin grant logic (purely combinational).
//
// Ports:
//   req      [1:0] in   request vector, bit 0 = A, bit 1 = B
//   last_gnt       in   requester granted most recently (0 = A, 1 = B)
//   gnt      [1:0] out  one-hot grant, 2'b00 when nothing is requested
//
// A lone request is granted immediately; on a tie the requester that was
// not granted last wins.
// ---------------------------------------------------------------------------
module cs_rr_arb2
  import cs_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = GNT_NONE;
    case (req)
      2'b01:   gnt = GNT_A;
      2'b10:   gnt = GNT_B;
      2'b11:   gnt = last_gnt ? GNT_A : GNT_B;
      default: gnt = GNT_NONE;
    endcase
  end

endmodule : cs_rr_arb2

// File: rtl/cs_sched.sv
// ---------------------------------------------------------------------------
// cs_sched -- schedules checksum jobs from two requesters onto one engine.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_a/req_b                job request, held until the matching ack
//   data_a/data_b              payload, stable while its req is high
//   ack_a/ack_b                one-cycle pulse when the payload is issued
//   done_a/done_b              one-cycle pulse when the result is valid
//   result_a/result_b          result, non-zero only alongside done
//   eng_in_valid, eng_data     engine issue strobe and held payload
//   eng_out_valid, eng_result  engine completion strobe and result
//   busy                       high whenever the FSM is not IDLE
//   timeout_err                pulse with done when a job was abandoned
//
// One job is outstanding at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Every output is a flop; each flop's next value is formed in one
// always_comb block from the current state, so an output pulse appears in
// the cycle of the state it belongs to.
// ---------------------------------------------------------------------------
module cs_sched
  import cs_pkg::*;
#(
  parameter int WIDTH_DATA   = DEF_WIDTH_DATA,
  parameter int WIDTH_RESULT = DEF_WIDTH_RESULT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_a,
  input  logic                    req_b,
  input  logic [WIDTH_DATA-1:0]   data_a,
  input  logic [WIDTH_DATA-1:0]   data_b,
  output logic                    ack_a,
  output logic                    ack_b,
  output logic                    done_a,
  output logic                    done_b,
  output logic [WIDTH_RESULT-1:0] result_a,
  output logic [WIDTH_RESULT-1:0] result_b,
  output logic                    eng_in_valid,
  output logic [WIDTH_DATA-1:0]   eng_data,
  input  logic                    eng_out_valid,
  input  logic [WIDTH_RESULT-1:0] eng_result,
  output logic                    busy,
  output logic                    timeout_err
);

  // WAIT lasts TIMEOUT cycles: the counter runs 0..TIMEOUT-1 and the job is
  // abandoned at the edge that ends the cycle in which it reads TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                  state_q, state_d;
  logic [1:0]              gnt_q, gnt_d;
  logic                    last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH_DATA-1:0]   eng_data_q, eng_data_d;
  logic                    eng_in_valid_q, eng_in_valid_d;
  logic                    ack_a_q, ack_a_d;
  logic                    ack_b_q, ack_b_d;
  logic                    done_a_q, done_a_d;
  logic                    done_b_q, done_b_d;
  logic [WIDTH_RESULT-1:0] result_a_q, result_a_d;
  logic [WIDTH_RESULT-1:0] result_b_q, result_b_d;
  logic                    timeout_err_q, timeout_err_d;
  logic                    busy_q, busy_d;

  logic [1:0]              arb_gnt;
  logic                    resp_fire;
  logic                    resp_timeout;
  logic [WIDTH_RESULT-1:0] resp_value;

  cs_rr_arb2 u_arb (
    .req      ({req_b, req_a}),
    .last_gnt (last_gnt_q),
    .gnt      (arb_gnt)
  );

  // Leaving WAIT: the engine result has priority over a timeout that
  // expires in the same cycle, so an answer arriving on the last allowed
  // cycle is still delivered as a normal completion.
  always_comb begin
    resp_fire    = 1'b0;
    resp_timeout = 1'b0;
    resp_value   = '0;
    if (state_q == ST_WAIT) begin
      if (eng_out_valid) begin
        resp_fire  = 1'b1;
        resp_value = eng_result;
      end else if (cnt_q == CNT_LAST) begin
        resp_fire    = 1'b1;
        resp_timeout = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    last_gnt_d     = last_gnt_q;
    cnt_d          = cnt_q;
    eng_data_d     = eng_data_q;
    eng_in_valid_d = 1'b0;
    ack_a_d        = 1'b0;
    ack_b_d        = 1'b0;
    done_a_d       = 1'b0;
    done_b_d       = 1'b0;
    result_a_d     = '0;
    result_b_d     = '0;
    timeout_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Capture the winner's payload now so it is already on eng_data
        // during the ISSUE cycle. The loser's req is left untouched and
        // competes again on the next IDLE cycle.
        if (arb_gnt != GNT_NONE) begin
          gnt_d          = arb_gnt;
          eng_data_d     = arb_gnt[1] ? data_b : data_a;
          eng_in_valid_d = 1'b1;
          ack_a_d        = arb_gnt[0];
          ack_b_d        = arb_gnt[1];
          state_d        = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (resp_fire) begin
          done_a_d      = gnt_q[0];
          done_b_d      = gnt_q[1];
          result_a_d    = gnt_q[0] ? resp_value : '0;
          result_b_d    = gnt_q[1] ? resp_value : '0;
          timeout_err_d = resp_timeout;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RESP: begin
        // Pointer moves only once a job has completed, so a job dropped by
        // reset never shifts the round-robin order.
        last_gnt_d = gnt_q[1];
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Reset puts A first in line by pretending B was granted last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      gnt_q          <= GNT_NONE;
      last_gnt_q     <= 1'b1;
      cnt_q          <= '0;
      eng_data_q     <= '0;
      eng_in_valid_q <= 1'b0;
      ack_a_q        <= 1'b0;
      ack_b_q        <= 1'b0;
      done_a_q       <= 1'b0;
      done_b_q       <= 1'b0;
      result_a_q     <= '0;
      result_b_q     <= '0;
      timeout_err_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      last_gnt_q     <= last_gnt_d;
      cnt_q          <= cnt_d;
      eng_data_q     <= eng_data_d;
      eng_in_valid_q <= eng_in_valid_d;
      ack_a_q        <= ack_a_d;
      ack_b_q        <= ack_b_d;
      done_a_q       <= done_a_d;
      done_b_q       <= done_b_d;
      result_a_q     <= result_a_d;
      result_b_q     <= result_b_d;
      timeout_err_q  <= timeout_err_d;
      busy_q         <= busy_d;
    end
  end

  assign ack_a        = ack_a_q;
  assign ack_b        = ack_b_q;
  assign done_a       = done_a_q;
  assign done_b       = done_b_q;
  assign result_a     = result_a_q;
  assign result_b     = result_b_q;
  assign eng_in_valid = eng_in_valid_q;
  assign eng_data     = eng_data_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;

endmodule : cs_sched

// File: tb/tb_cs_sched.sv
// ---------------------------------------------------------------------------
// tb_cs_sched -- directed self-checking bench for cs_sched.
//
// Two requester models and an engine model run inside tick(). Expected
// grant order is queued when requests are raised; expected results are
// queued when the DUT issues a job and compared when done is seen.
// ---------------------------------------------------------------------------
module tb_cs_sched;

  localparam int WD = 512;
  localparam int WR = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_a = 1'b0;
  logic          req_b = 1'b0;
  logic [WD-1:0] data_a = '0;
  logic [WD-1:0] data_b = '0;
  logic          ack_a, ack_b, done_a, done_b;
  logic [WR-1:0] result_a, result_b;
  logic          eng_in_valid;
  logic [WD-1:0] eng_data;
  logic          eng_out_valid = 1'b0;
  logic [WR-1:0] eng_result = '0;
  logic          busy, timeout_err;

  always #5 clk = ~clk;

  cs_sched #(
    .WIDTH_DATA   (WD),
    .WIDTH_RESULT (WR),
    .TIMEOUT      (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_a         (req_a),
    .req_b         (req_b),
    .data_a        (data_a),
    .data_b        (data_b),
    .ack_a         (ack_a),
    .ack_b         (ack_b),
    .done_a        (done_a),
    .done_b        (done_b),
    .result_a      (result_a),
    .result_b      (result_b),
    .eng_in_valid  (eng_in_valid),
    .eng_data      (eng_data),
    .eng_out_valid (eng_out_valid),
    .eng_result    (eng_result),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    logic          who_b;
    logic [WR-1:0] res;
    logic          terr;
  } exp_t;

  exp_t exp_q[$];
  logic gnt_exp[$];

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_done = 0;
  int last_issue_cyc = 0;
  int last_done_cyc = 0;
  int req_cyc = 0;
  int rem_a = 0;
  int rem_b = 0;
  int eng_cnt = -1;
  int eng_lat = 1;
  logic eng_silent = 1'b0;
  logic [WR-1:0] next_val = '0;
  logic [WR-1:0] val_step = '0;
  logic [WR-1:0] cur_val = '0;

  task automatic chk_core(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk_core(tag, WD'(obs), WD'(exp));
  endtask

  task automatic chk16(input string tag, input logic [WR-1:0] obs, input logic [WR-1:0] exp);
    chk_core(tag, WD'(obs), WD'(exp));
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    chk_core(tag, WD'(obs), WD'(exp));
  endtask

  task automatic rand_data(output logic [WD-1:0] d);
    for (int i = 0; i < WD / 32; i++) d[i*32 +: 32] = $urandom();
  endtask

  // One clock: advance to just after the rising edge, run the engine and
  // requester models, and check whatever the DUT presents this cycle.
  task automatic tick();
    exp_t e;
    logic eb;
    @(posedge clk);
    #1;
    cyc++;
    eng_out_valid = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_out_valid = 1'b1;
        eng_result    = cur_val;
        eng_cnt       = -1;
      end
    end

    if (eng_in_valid) begin
      last_issue_cyc = cyc;
      if (gnt_exp.size() == 0) begin
        chk1("unexpected_issue", eng_in_valid, 1'b0);
      end else begin
        eb = gnt_exp.pop_front();
        chk1("grant_ack_b", ack_b, eb);
        chk1("grant_ack_a", ack_a, !eb);
        chk_core("eng_data", eng_data, eb ? data_b : data_a);
        cur_val  = next_val;
        next_val = next_val + val_step;
        e.who_b  = eb;
        e.res    = eng_silent ? '0 : cur_val;
        e.terr   = eng_silent;
        exp_q.push_back(e);
        if (!eng_silent) eng_cnt = eng_lat;
      end
      if (ack_a) begin
        rem_a--;
        if (rem_a > 0) rand_data(data_a);
        else req_a = 1'b0;
      end
      if (ack_b) begin
        rem_b--;
        if (rem_b > 0) rand_data(data_b);
        else req_b = 1'b0;
      end
    end else begin
      chk1("ack_without_issue", ack_a | ack_b, 1'b0);
    end

    if (done_a || done_b) begin
      last_done_cyc = cyc;
      n_done++;
      if (exp_q.size() == 0) begin
        chk1("unexpected_done", done_a | done_b, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk1("done_b", done_b, e.who_b);
        chk1("done_a", done_a, !e.who_b);
        chk16("result_b", result_b, e.who_b ? e.res : '0);
        chk16("result_a", result_a, e.who_b ? '0 : e.res);
        chk1("timeout_err", timeout_err, e.terr);
      end
    end else begin
      chk16("result_outside_done", result_a | result_b, '0);
      chk1("terr_outside_done", timeout_err, 1'b0);
    end
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (i < budget && (exp_q.size() != 0 || gnt_exp.size() != 0 ||
                          req_a || req_b || busy)) begin
      tick();
      i++;
    end
    chki("drain_pending", exp_q.size() + gnt_exp.size(), 0);
    chk1("drain_busy", busy, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_ack"}, ack_a | ack_b, 1'b0);
    chk1({tag, "_done"}, done_a | done_b, 1'b0);
    chk16({tag, "_result"}, result_a | result_b, '0);
    chk1({tag, "_in_valid"}, eng_in_valid, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_terr"}, timeout_err, 1'b0);
    chk_core({tag, "_eng_data"}, eng_data, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single A job, engine answers after 3 cycles
    data_a = 512'h1;
    rem_a = 1; eng_lat = 3; eng_silent = 1'b0;
    next_val = 16'hA55A; val_step = '0;
    gnt_exp.push_back(1'b0);
    base = n_done;
    req_cyc = cyc;
    req_a = 1'b1;
    drain(40);
    chki("t1_jobs", n_done - base, 1);
    chki("t1_ack_latency", last_issue_cyc - req_cyc, 1);
    chki("t1_done_latency", last_done_cyc - last_issue_cyc, 4);

    // Simultaneous requests after reset: A then B
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rand_data(data_a);
    rand_data(data_b);
    data_b[0] = ~data_a[0];
    rem_a = 1; rem_b = 1; eng_lat = 2;
    next_val = 16'h1234; val_step = 16'h0101;
    gnt_exp.push_back(1'b0);
    gnt_exp.push_back(1'b1);
    base = n_done;
    req_a = 1'b1;
    req_b = 1'b1;
    drain(60);
    chki("t2_jobs", n_done - base, 2);

    // Continuous contention, six jobs alternate A,B,A,B,A,B
    rand_data(data_a);
    rand_data(data_b);
    rem_a = 3; rem_b = 3; eng_lat = 1;
    next_val = 16'h0F0F; val_step = 16'h1357;
    for (int i = 0; i < 3; i++) begin
      gnt_exp.push_back(1'b0);
      gnt_exp.push_back(1'b1);
    end
    base = n_done;
    req_a = 1'b1;
    req_b = 1'b1;
    drain(150);
    chki("t3_jobs", n_done - base, 6);

    // Silent engine: abandoned after TO WAIT cycles
    rand_data(data_a);
    rem_a = 1; eng_silent = 1'b1;
    gnt_exp.push_back(1'b0);
    base = n_done;
    req_a = 1'b1;
    drain(40);
    chki("t4_jobs", n_done - base, 1);
    chki("t4_timeout_latency", last_done_cyc - last_issue_cyc, TO + 1);

    // Engine answers in the very cycle the timeout expires
    rand_data(data_b);
    rem_b = 1; eng_silent = 1'b0; eng_lat = TO;
    next_val = 16'hBEEF; val_step = '0;
    gnt_exp.push_back(1'b1);
    base = n_done;
    req_b = 1'b1;
    drain(40);
    chki("t5_jobs", n_done - base, 1);
    chki("t5_done_latency", last_done_cyc - last_issue_cyc, TO + 1);

    // Stray eng_out_valid while IDLE
    eng_out_valid = 1'b1;
    eng_result = 16'hFFFF;
    tick();
    chk1("stray_busy", busy, 1'b0);
    chk1("stray_done", done_a | done_b, 1'b0);
    chk1("stray_in_valid", eng_in_valid, 1'b0);
    tick();
    chk1("stray_busy2", busy, 1'b0);

    // Reset during WAIT drops the job
    rand_data(data_a);
    rem_a = 1; eng_lat = 3;
    next_val = 16'h7777;
    gnt_exp.push_back(1'b0);
    req_a = 1'b1;
    for (int i = 0; i < 5 && !eng_in_valid; i++) tick();
    chk1("t6_issued", eng_in_valid, 1'b1);
    tick();
    chk1("t6_busy_in_wait", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_async_reset");
    exp_q.delete();
    eng_cnt = -1;
    base = n_done;
    tick();
    rst_n = 1'b1;
    tick();
    eng_out_valid = 1'b1;
    eng_result = 16'h7777;
    for (int i = 0; i < 4; i++) tick();
    chki("t6_no_done", n_done - base, 0);
    chk1("t6_idle_after_reset", busy, 1'b0);

    // Next job after the dropped one completes normally
    rand_data(data_a);
    rem_a = 1; eng_lat = 2;
    next_val = 16'h5AA5;
    gnt_exp.push_back(1'b0);
    base = n_done;
    req_a = 1'b1;
    drain(40);
    chki("t6_next_job", n_done - base, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_cs_sched

// File: doc/cs_sched.md
CS_SCHED -- requirements
Module: cs_sched

Interface
REQ-001 Parameter WIDTH_DATA, default 512: checksum payload width (384-bit field 1 + 128-bit field 2).
REQ-002 Parameter WIDTH_RESULT, default 16: checksum result width (8-bit result 1 + 8-bit result 2).
REQ-003 Parameter TIMEOUT, default 1023: maximum WAIT cycles before a job is abandoned; legal range 1 to 65535.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_a / req_b  input  1  job request from requester A / B; held high until the matching ack.
REQ-007 data_a / data_b  input  WIDTH_DATA  payload from requester A / B; stable while its req is high.
REQ-008 ack_a / ack_b  output  1  one-cycle pulse when that requester's payload is captured and issued.
REQ-009 done_a / done_b  output  1  one-cycle pulse when the result for that requester is valid.
REQ-010 result_a / result_b  output  WIDTH_RESULT  result for A / B; valid only while the matching done is high, 0 otherwise.
REQ-011 eng_in_valid  output  1  one-cycle pulse to the checksum engine in_valid.
REQ-012 eng_data  output  WIDTH_DATA  payload to the engine; holds the last issued payload.
REQ-013 eng_out_valid  input  1  engine out_valid.
REQ-014 eng_result  input  WIDTH_RESULT  engine result; sampled only with eng_out_valid.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 timeout_err  output  1  one-cycle pulse, coincident with done, for an abandoned job.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT and RESP, with at most one job outstanding.
REQ-018 IDLE: if either req is high at a rising edge, choose a grant, capture that requester's data into eng_data, and go to ISSUE; otherwise stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: on a tie, grant the requester that was not granted last; after reset A has priority; a lone request is granted at once.
REQ-020 ISSUE lasts one cycle: eng_in_valid=1 and ack of the granted requester=1, then go to WAIT.
REQ-021 WAIT: on eng_out_valid=1, register eng_result and go to RESP; otherwise increment a wait counter cleared on entry to WAIT.
REQ-022 When the wait counter reaches TIMEOUT without eng_out_valid, go to RESP with a zero result and timeout_err=1 during RESP.
REQ-023 If eng_out_valid and the timeout occur in the same cycle, the engine result wins and timeout_err stays 0.
REQ-024 RESP lasts one cycle: done and result of the granted requester are valid, the round-robin pointer is updated to the granted requester, then go to IDLE.
REQ-025 Latency: req sampled at edge k gives ack at cycle k+1, eng_in_valid at cycle k+1, and done one cycle after the eng_out_valid edge.
REQ-026 eng_out_valid in IDLE, ISSUE or RESP SHALL be ignored with no effect on state or outputs.
REQ-027 The non-granted requester's req SHALL stay pending, unacknowledged, and is arbitrated on the next IDLE cycle.
REQ-028 Back-to-back throughput: a new job may be granted in the IDLE cycle directly after RESP; IDLE is never skipped.
REQ-029 The ungranted requester's ack, done and result SHALL stay 0.

Reset
REQ-030 While rst_n=0: state=IDLE, round-robin pointer set to favour A, wait counter=0, eng_data=0.
REQ-031 While rst_n=0, every output SHALL be 0: ack_*, done_*, result_*, eng_in_valid, busy and timeout_err.
REQ-032 Reset asserted mid-job SHALL drop the job silently, with no done pulse afterwards; a late eng_out_valid is ignored per REQ-026.

Structure
REQ-033 A shared package cs_pkg SHALL hold the state enum, the default widths (512/16) and the default TIMEOUT.
REQ-034 The round-robin grant logic SHALL be one sub-module, cs_rr_arb2, taking req[1:0] and last-grant and producing a one-hot grant.
REQ-035 All outputs SHALL be registered; there are no combinational paths from input to output.

Verification
REQ-036 Single A job: req_a=1 with data_a=512'h1 and the engine replies after 3 cycles with 16'hA55A -> one ack_a, then done_a with result_a=16'hA55A; B outputs stay 0.
REQ-037 Simultaneous requests after reset: both req with distinct data -> A served first, B second; eng_data matches each payload in its ISSUE cycle.
REQ-038 Continuous contention for 6 jobs -> grants alternate A,B,A,B,A,B; no starvation occurs.
REQ-039 Timeout with TIMEOUT=4 and a silent engine -> done with result=0 and timeout_err=1 exactly 4 WAIT cycles after ISSUE; FSM returns to IDLE.
REQ-040 Timeout coincident with eng_out_valid -> result equals eng_result and timeout_err=0; a stray eng_out_valid in IDLE -> no output change.
REQ-041 rst_n pulsed low during WAIT -> all outputs 0 immediately; no done follows; the next job completes normally.
